// File: rtl/lenet_hw_mul_share_arb.sv
// Round-robin arbiter sharing one external 49x44 multiplier among NUM_REQ MAC lanes.
// Optional LENET_MUL_ARB_PERF_EN adds a saturating accepted-request counter (perf_grant_cnt).
module lenet_hw_mul_share_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned DIN0_WIDTH = 49,
    parameter int unsigned DIN1_WIDTH = 44,
    parameter int unsigned DOUT_WIDTH = 93
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
    output logic [DIN0_WIDTH-1:0]            mul_din0,
    output logic [DIN1_WIDTH-1:0]            mul_din1,
    input  logic [DOUT_WIDTH-1:0]            mul_dout,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DOUT_WIDTH-1:0]            rsp_dout,
`ifdef LENET_MUL_ARB_PERF_EN
    output logic [31:0]                      perf_grant_cnt,
`endif
    output logic [ID_WIDTH-1:0]              rsp_id
);

    logic                  op_valid_q;
    logic [ID_WIDTH-1:0]   op_id_q;
    logic [ID_WIDTH-1:0]   rr_ptr_q;
    logic [DIN0_WIDTH-1:0] din0_q;
    logic [DIN1_WIDTH-1:0] din1_q;
    logic                  rsp_valid_q;
    logic [ID_WIDTH-1:0]   rsp_id_q;
    logic [DOUT_WIDTH-1:0] rsp_dout_q;

    logic                  b_load;
    logic                  a_free;
    logic                  grant_any;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   rr_ptr_d;
    logic [DIN0_WIDTH-1:0] sel_din0;
    logic [DIN1_WIDTH-1:0] sel_din1;

    assign b_load = op_valid_q && (!rsp_valid_q || rsp_ready);
    assign a_free = !op_valid_q || b_load;

    // Scan offsets from rr_ptr outward; the outer loop order gives the rotating priority.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        rr_ptr_d  = rr_ptr_q;
        sel_din0  = '0;
        sel_din1  = '0;
        if (a_free) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (!grant_any && req_valid[i] &&
                        (i == ((32'(rr_ptr_q) + k) % NUM_REQ))) begin
                        grant_any = 1'b1;
                        grant[i]  = 1'b1;
                        grant_id  = ID_WIDTH'(i);
                        rr_ptr_d  = ID_WIDTH'((i + 1) % NUM_REQ);
                        sel_din0  = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
                        sel_din1  = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            op_valid_q  <= 1'b0;
            op_id_q     <= '0;
            rr_ptr_q    <= '0;
            din0_q      <= '0;
            din1_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_dout_q  <= '0;
        end else begin
            if (grant_any) begin
                op_valid_q <= 1'b1;
                op_id_q    <= grant_id;
                din0_q     <= sel_din0;
                din1_q     <= sel_din1;
                rr_ptr_q   <= rr_ptr_d;
            end else if (b_load) begin
                op_valid_q <= 1'b0;
            end

            if (b_load) begin
                rsp_dout_q <= mul_dout;
                rsp_id_q   <= op_id_q;
            end

            if (b_load) begin
                rsp_valid_q <= 1'b1;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

`ifdef LENET_MUL_ARB_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            perf_q <= '0;
        end else if (grant_any && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_grant_cnt = perf_q;
`endif

    assign req_ready = grant;
    assign mul_din0  = din0_q;
    assign mul_din1  = din1_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_dout  = rsp_dout_q;

endmodule

// File: tb/tb_lenet_hw_mul_share_arb.sv
// Scoreboard bench for lenet_hw_mul_share_arb; models the external multiplier combinationally.
module tb_lenet_hw_mul_share_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned W0 = 49;
    localparam int unsigned W1 = 44;
    localparam int unsigned WO = 93;

    typedef struct packed {
        logic [1:0]    id;
        logic [WO-1:0] dout;
    } exp_t;

    logic            clk;
    logic            ap_rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W0-1:0] req_din0;
    logic [N*W1-1:0] req_din1;
    logic [W0-1:0]   mul_din0;
    logic [W1-1:0]   mul_din1;
    logic [WO-1:0]   mul_dout;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [WO-1:0]   rsp_dout;
    logic [1:0]      rsp_id;
`ifdef LENET_MUL_ARB_PERF_EN
    logic [31:0]     perf_grant_cnt;
`endif

    logic [W0-1:0] a [N];
    logic [W1-1:0] b [N];
    exp_t          sb [$];
    int            n_cmp;
    int            n_fail;

    lenet_hw_mul_share_arb dut (
        .ap_clk    (clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_din0  (req_din0),
        .req_din1  (req_din1),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dout  (rsp_dout),
`ifdef LENET_MUL_ARB_PERF_EN
        .perf_grant_cnt (perf_grant_cnt),
`endif
        .rsp_id    (rsp_id)
    );

    assign mul_dout = WO'(mul_din0) * WO'(mul_din1);

    always_comb begin
        req_din0 = '0;
        req_din1 = '0;
        for (int i = 0; i < N; i++) begin
            req_din0[i*W0 +: W0] = a[i];
            req_din1[i*W1 +: W1] = b[i];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WO-1:0] act, input logic [WO-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Checks req_ready for the cycle and queues the expected product for any granted lane.
    task automatic step(input logic [N-1:0] exp_rdy, input bit push, input string name);
        exp_t e;
        @(negedge clk);
        chk(name, WO'(req_ready), WO'(exp_rdy));
        if (push) begin
            for (int i = 0; i < N; i++) begin
                if (exp_rdy[i]) begin
                    e.id   = 2'(i);
                    e.dout = WO'(a[i]) * WO'(b[i]);
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        req_valid = '0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        @(posedge clk);
        #1;
        ap_rst = 1'b0;
    endtask

    // Monitor: every accepted response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!ap_rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d dout %0h, expected none", rsp_id, rsp_dout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", WO'(rsp_id), WO'(e.id));
                chk("rsp_dout", rsp_dout, e.dout);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        ap_rst    = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        ap_rst = 1'b0;

        @(negedge clk);
        chk("rst_rsp_valid", WO'(rsp_valid), '0);
        chk("rst_rsp_dout", rsp_dout, '0);
        chk("rst_rsp_id", WO'(rsp_id), '0);
        chk("rst_mul_din0", WO'(mul_din0), '0);
        chk("rst_mul_din1", WO'(mul_din1), '0);
        @(posedge clk);
        #1;

        // Single op 3*5 from lane 0, with latency check.
        a[0] = 49'd3;
        b[0] = 44'd5;
        req_valid = 4'b0001;
        step(4'b0001, 1'b1, "single_grant");
        req_valid = '0;
        @(negedge clk);
        chk("lat_k", WO'(rsp_valid), '0);
        @(negedge clk);
        chk("lat_k1", WO'(rsp_valid), WO'(1'b1));
        chk("single_dout", rsp_dout, 93'd15);
        idle(2);

        // Max operands on lane 2.
        a[2] = '1;
        b[2] = '1;
        req_valid = 4'b0100;
        step(4'b0100, 1'b1, "max_grant");
        idle(4);

        // Round-robin from reset pointer 0, all lanes requesting.
        do_reset();
        for (int i = 0; i < N; i++) begin
            a[i] = W0'(10 + i);
            b[i] = W1'(100 + i);
        end
        req_valid = 4'b1111;
        step(4'b0001, 1'b1, "rr0");
        step(4'b0010, 1'b1, "rr1");
        step(4'b0100, 1'b1, "rr2");
        step(4'b1000, 1'b1, "rr3");
        step(4'b0001, 1'b1, "rr4");
        step(4'b0010, 1'b1, "rr5");
        idle(4);

        // Backpressure on a lane-1 stream.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        a[1] = 49'd7;
        b[1] = 44'd9;
        step(4'b0010, 1'b1, "bp_g0");
        a[1] = 49'd11;
        b[1] = 44'd13;
        step(4'b0010, 1'b1, "bp_g1");
        a[1] = 49'd17;
        b[1] = 44'd19;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("bp_ready_full", WO'(req_ready), '0);
            chk("bp_hold_valid", WO'(rsp_valid), WO'(1'b1));
            chk("bp_hold_dout", rsp_dout, 93'd63);
            chk("bp_hold_id", WO'(rsp_id), 93'd1);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        step(4'b0010, 1'b1, "bp_release");
        idle(5);

        // Reset the cycle after a grant: that op must vanish.
        a[0] = 49'd21;
        b[0] = 44'd23;
        req_valid = 4'b0001;
        step(4'b0001, 1'b0, "rst_mid_grant");
        req_valid = '0;
        do_reset();
        @(negedge clk);
        chk("rst_mid_rsp_valid", WO'(rsp_valid), '0);
        chk("rst_mid_mul_din0", WO'(mul_din0), '0);
        @(negedge clk);
        chk("rst_mid_rsp_valid2", WO'(rsp_valid), '0);
        idle(3);
        a[3] = 49'd29;
        b[3] = 44'd31;
        req_valid = 4'b1000;
        step(4'b1000, 1'b1, "post_rst_req3");
        idle(4);

        // Ten back-to-back ops on lane 0 at full throughput.
        do_reset();
        req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            a[0] = W0'(i + 1);
            b[0] = 44'd2;
            step(4'b0001, 1'b1, "burst");
        end
        idle(4);
`ifdef LENET_MUL_ARB_PERF_EN
        @(negedge clk);
        chk("perf_10", WO'(perf_grant_cnt), 93'd10);
        do_reset();
        @(negedge clk);
        chk("perf_rst", WO'(perf_grant_cnt), '0);
`endif

        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d outstanding, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
